secuenciador_modo_reto: RTL and testbench

//  Sequencer for challenge mode. It generates a pseudo-random pattern of notes and

---
 rtl/secuenciador_modo_reto.sv | 145 ++++++++++++++
 tb/tb_secuenciador_modo_reto.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_modo_reto.sv
// Challenge-mode sequencer: builds a pseudo-random note pattern from an LFSR, presents it
// note by note, then scores the player's keypad answers against it.
module secuenciador_modo_reto #(
   parameter int N_NOTAS  = 8,
   parameter int T_NOTA   = 50,
   parameter int T_ESPERA = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inicio,
   input  logic [7:0] notaUsuario,
   output logic [2:0] notaSalida,
   output logic       notaValida,
   output logic       juegoListo,
   output logic       finJuego,
   output logic       contarNotas,
   output logic [3:0] aciertos
);

   localparam int T_MAX = (T_NOTA > T_ESPERA) ? T_NOTA : T_ESPERA;
   localparam int IW    = (N_NOTAS > 1) ? $clog2(N_NOTAS) : 1;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [IW-1:0] IDX_ULTIMO  = IW'(N_NOTAS - 1);
   localparam logic [TW-1:0] T_NOTA_FIN  = TW'(T_NOTA - 1);
   localparam logic [TW-1:0] T_ESPER_FIN = TW'(T_ESPERA - 1);
   localparam logic [3:0]    ACIERTO_MAX = 4'(N_NOTAS);

   typedef enum logic [2:0] {REPOSO, GENERAR, MOSTRAR, ESPERAR, FIN} estado_t;

   estado_t       estado_q, estado_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [7:0]    u_q, u_d;
   logic [7:0]    u_prev_q, u_prev_d;
   logic          contar_q, contar_d;
   logic [3:0]    aciertos_q, aciertos_d;
   logic [2:0]    pattern_q [N_NOTAS];
   logic [2:0]    pattern_d [N_NOTAS];
   logic          ev;
   logic          acierto;

   // A key counts only on its press edge, so a held key is scored once.
   assign ev      = (u_q != 8'd0) && (u_prev_q == 8'd0);
   assign acierto = ev && (u_q == (8'd1 << pattern_q[idx_q]));

   always_comb begin
      estado_d   = estado_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      u_d        = notaUsuario;
      u_prev_d   = u_q;
      contar_d   = 1'b0;
      aciertos_d = aciertos_q;
      pattern_d  = pattern_q;
      case (estado_q)
         REPOSO, FIN: begin
            if (inicio) begin
               estado_d   = GENERAR;
               aciertos_d = 4'd0;
               idx_d      = '0;
               timer_d    = '0;
            end
         end
         GENERAR: begin
            pattern_d[idx_q] = lfsr_q[2:0];
            if (idx_q == IDX_ULTIMO) begin
               idx_d    = '0;
               timer_d  = '0;
               estado_d = MOSTRAR;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         MOSTRAR: begin
            if (timer_q == T_NOTA_FIN) begin
               timer_d = '0;
               if (idx_q == IDX_ULTIMO) begin
                  idx_d    = '0;
                  estado_d = ESPERAR;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ESPERAR: begin
            // A key event takes priority over a timeout landing in the same cycle.
            if (ev || (timer_q == T_ESPER_FIN)) begin
               timer_d = '0;
               if (acierto) begin
                  contar_d = 1'b1;
                  if (aciertos_q != ACIERTO_MAX) aciertos_d = aciertos_q + 4'd1;
               end
               if (idx_q == IDX_ULTIMO) begin
                  idx_d    = '0;
                  estado_d = FIN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: estado_d = REPOSO;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q   <= REPOSO;
         idx_q      <= '0;
         timer_q    <= '0;
         lfsr_q     <= 8'hA5;
         u_q        <= 8'd0;
         u_prev_q   <= 8'd0;
         contar_q   <= 1'b0;
         aciertos_q <= 4'd0;
      end else begin
         estado_q   <= estado_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         lfsr_q     <= lfsr_d;
         u_q        <= u_d;
         u_prev_q   <= u_prev_d;
         contar_q   <= contar_d;
         aciertos_q <= aciertos_d;
      end
   end

   // Pattern storage is pure data; its contents after reset do not matter.
   always_ff @(posedge clk) begin
      pattern_q <= pattern_d;
   end

   assign notaValida  = (estado_q == MOSTRAR);
   assign notaSalida  = notaValida ? pattern_q[idx_q] : 3'd0;
   assign juegoListo  = (estado_q == REPOSO);
   assign finJuego    = (estado_q == FIN);
   assign contarNotas = contar_q;
   assign aciertos    = aciertos_q;

endmodule

// File: tb/tb_secuenciador_modo_reto.sv
// Directed bench for secuenciador_modo_reto with a small round of 4 notes.
module tb_secuenciador_modo_reto;

   localparam int N  = 4;
   localparam int TN = 3;
   localparam int TE = 10;

   logic       clk;
   logic       reset;
   logic       inicio;
   logic [7:0] notaUsuario;
   logic [2:0] notaSalida;
   logic       notaValida;
   logic       juegoListo;
   logic       finJuego;
   logic       contarNotas;
   logic [3:0] aciertos;

   int         n_cmp = 0;
   int         n_err = 0;
   int         pulsos = 0;
   logic [7:0] m;
   logic [2:0] exp_pat [N];

   secuenciador_modo_reto #(.N_NOTAS(N), .T_NOTA(TN), .T_ESPERA(TE)) dut (
      .clk(clk), .reset(reset), .inicio(inicio), .notaUsuario(notaUsuario),
      .notaSalida(notaSalida), .notaValida(notaValida), .juegoListo(juegoListo),
      .finJuego(finJuego), .contarNotas(contarNotas), .aciertos(aciertos)
   );

   initial clk = 1'b1;
   always #20 clk = ~clk;

   // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5.
   always @(posedge clk or posedge reset) begin
      if (reset) m <= 8'hA5;
      else       m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] onehot(input logic [2:0] n);
      return 8'd1 << n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickc();
      tick();
      if (contarNotas) pulsos++;
   endtask

   task automatic press(input logic [7:0] v, input int hold, input int rel);
      notaUsuario = v;
      repeat (hold) tickc();
      notaUsuario = 8'd0;
      repeat (rel) tickc();
   endtask

   // Starts a round, predicts the pattern from the reference LFSR and checks the playback.
   task automatic start_round(input bit hold_first, input bit poke_inicio);
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      chk("gen_finJuego", finJuego, 0);
      chk("gen_aciertos", aciertos, 0);
      chk("gen_juegoListo", juegoListo, 0);
      for (int i = 0; i < N; i++) begin
         exp_pat[i] = m[2:0];
         tick();
      end
      for (int k = 0; k < N * TN; k++) begin
         chk("mostrar_valida", notaValida, 1);
         chk("mostrar_nota", notaSalida, exp_pat[k / TN]);
         if (poke_inicio && k == 3) inicio = 1'b1;
         if (k == 4) inicio = 1'b0;
         if (hold_first && k == 6) notaUsuario = onehot(exp_pat[0]);
         tickc();
      end
      chk("esperar_valida", notaValida, 0);
      chk("esperar_nota", notaSalida, 0);
   endtask

   initial begin
      int n;
      int malos;
      reset = 1'b1;
      inicio = 1'b1;
      notaUsuario = 8'd0;

      // 1: reset held with inicio high
      #30;
      chk("rst_juegoListo", juegoListo, 1);
      chk("rst_notaValida", notaValida, 0);
      chk("rst_notaSalida", notaSalida, 0);
      chk("rst_finJuego", finJuego, 0);
      chk("rst_contar", contarNotas, 0);
      chk("rst_aciertos", aciertos, 0);
      #60;
      chk("rst_sigue_reposo", juegoListo, 1);
      inicio = 1'b0;
      #10 reset = 1'b0;
      tick();
      chk("reposo_tras_rst", juegoListo, 1);

      // 2: full correct round
      pulsos = 0;
      start_round(1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         press(onehot(exp_pat[i]), 2, 2);
         chk("t2_aciertos_parcial", aciertos, i + 1);
      end
      chk("t2_pulsos", pulsos, 4);
      chk("t2_aciertos", aciertos, 4);
      chk("t2_finJuego", finJuego, 1);

      // 3: no keys, every answer times out
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      chk("t3_aciertos_borrado", aciertos, 0);
      n = 0;
      malos = 0;
      while (!finJuego && n < 100) begin
         tick();
         n++;
         if (contarNotas) malos++;
      end
      chk("t3_latencia_fin", n, 4 + 12 + 40);
      chk("t3_aciertos", aciertos, 0);
      chk("t3_contar_nunca", malos, 0);

      // 4: multi-bit, wrong note, correct, correct held long
      pulsos = 0;
      start_round(1'b0, 1'b0);
      press(8'h03, 2, 2);
      chk("t4_multibit", aciertos, 0);
      press(onehot(exp_pat[1] + 3'd1), 2, 2);
      chk("t4_erronea", aciertos, 0);
      press(onehot(exp_pat[2]), 2, 2);
      chk("t4_correcta", aciertos, 1);
      press(onehot(exp_pat[3]), 30, 2);
      chk("t4_aciertos", aciertos, 2);
      chk("t4_pulsos", pulsos, 2);
      chk("t4_finJuego", finJuego, 1);

      // 5a: reset during MOSTRAR
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      repeat (6) tick();
      chk("t5a_en_mostrar", notaValida, 1);
      #5 reset = 1'b1;
      #1;
      chk("t5a_notaValida", notaValida, 0);
      chk("t5a_notaSalida", notaSalida, 0);
      chk("t5a_juegoListo", juegoListo, 1);
      chk("t5a_aciertos", aciertos, 0);
      tick();
      chk("t5a_reposo_rst", juegoListo, 1);
      #10 reset = 1'b0;
      tick();

      // 5b: reset during ESPERAR after one hit
      start_round(1'b0, 1'b0);
      press(onehot(exp_pat[0]), 2, 2);
      chk("t5b_previo", aciertos, 1);
      #5 reset = 1'b1;
      #1;
      chk("t5b_aciertos", aciertos, 0);
      chk("t5b_juegoListo", juegoListo, 1);
      chk("t5b_contar", contarNotas, 0);
      chk("t5b_finJuego", finJuego, 0);
      tick();
      #10 reset = 1'b0;
      tick();

      // 5c: new round; key pressed during MOSTRAR and held into ESPERAR is not an answer
      pulsos = 0;
      start_round(1'b1, 1'b0);
      repeat (3) tickc();
      notaUsuario = 8'd0;
      repeat (9) tickc();
      chk("t5c_mantenida", aciertos, 0);
      chk("t5c_pulsos_mantenida", pulsos, 0);
      for (int i = 1; i < N; i++) press(onehot(exp_pat[i]), 2, 2);
      chk("t5c_aciertos", aciertos, 3);
      chk("t5c_finJuego", finJuego, 1);

      // 6: restart from FIN, inicio pulsed during MOSTRAR is ignored
      pulsos = 0;
      start_round(1'b0, 1'b1);
      for (int i = 0; i < N; i++) press(onehot(exp_pat[i]), 2, 2);
      chk("t6_aciertos", aciertos, 4);
      chk("t6_pulsos", pulsos, 4);
      chk("t6_finJuego", finJuego, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
